// File: rtl/memory_arbiter_if.sv
// ----------------------------------------------------------------------------
// memory_arbiter_pkg / memory_arbiter_if
//
// Purpose : shared types and the bundled signal set of the memory arbiter.
//           The interface carries the fetch port (i_*), the load/store port
//           (d_*), the unified memory port (mem_*) and the sticky timeout flag.
//
// Modports:
//   slave  - the arbiter side: consumes requests and mem_ready/mem_rdata,
//            drives ready pulses, read data, the memory request and
//            timeout_err.
//   master - the environment side (core plus memory model), mirror image.
// ----------------------------------------------------------------------------
package memory_arbiter_pkg;
  // Per-byte enables of a 32-bit word, one bit per byte lane.
  typedef logic [3:0] memory_mask_t;
  localparam memory_mask_t MASK_WORD = 4'b1111;
endpackage

interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  // Fetch port
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_ready;
  logic [31:0]  i_rdata;
  // Load/store port
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [31:0]  d_wdata;
  memory_mask_t d_mask;
  logic         d_ready;
  logic [31:0]  d_rdata;
  // Unified memory port
  logic         mem_valid;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  memory_mask_t mem_mask;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  // Status
  logic         timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask,
           mem_ready, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_mask, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask,
           mem_ready, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_mask, timeout_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose : shares one single-port memory between the instruction-fetch port
//           and the load/store port. One requester is granted at a time; the
//           memory request is registered and held until mem_ready, then the
//           read data is returned with a one-cycle ready pulse. Data accesses
//           win arbitration, but after MAX_D_STREAK consecutive data grants
//           with a fetch waiting, the fetch goes next. A grant that waits
//           TIMEOUT cycles without mem_ready is aborted (TIMEOUT=0: never).
//
// Ports   :
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - memory_arbiter_if.slave (fetch, load/store, memory, timeout_err)
// ----------------------------------------------------------------------------
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  memory_arbiter_if.slave bus
);

  localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WAIT_LAST  = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t       state_q, state_d;
  logic         mem_valid_q, mem_valid_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  mem_wdata_q, mem_wdata_d;
  memory_mask_t mem_mask_q, mem_mask_d;
  logic         i_ready_q, i_ready_d;
  logic [31:0]  i_rdata_q, i_rdata_d;
  logic         d_ready_q, d_ready_d;
  logic [31:0]  d_rdata_q, d_rdata_d;
  logic         timeout_err_q, timeout_err_d;
  logic [SW-1:0] d_streak_q, d_streak_d;
  logic [WW-1:0] wait_q, wait_d;

  // A requester whose ready pulse is on the bus right now has already been
  // served; its still-high req must not start a second access.
  logic i_pend, d_pend;
  logic grant_i, grant_d, finish, abort;

  assign i_pend = bus.i_req & ~i_ready_q;
  assign d_pend = bus.d_req & ~d_ready_q;

  // State register (plus the registered datapath it steers).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_mask_q    <= '0;
      i_ready_q     <= 1'b0;
      i_rdata_q     <= '0;
      d_ready_q     <= 1'b0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
      d_streak_q    <= '0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_mask_q    <= mem_mask_d;
      i_ready_q     <= i_ready_d;
      i_rdata_q     <= i_rdata_d;
      d_ready_q     <= d_ready_d;
      d_rdata_q     <= d_rdata_d;
      timeout_err_q <= timeout_err_d;
      d_streak_q    <= d_streak_d;
      wait_q        <= wait_d;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/abort while busy.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend && !(i_pend && d_streak_q == STREAK_MAX)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (i_pend) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // A completion in the expiry cycle takes precedence over the abort.
        if (bus.mem_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of all registered outputs and counters.
  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_mask_d    = mem_mask_q;
    i_ready_d     = 1'b0;
    i_rdata_d     = '0;
    d_ready_d     = 1'b0;
    d_rdata_d     = '0;
    timeout_err_d = timeout_err_q;
    d_streak_d    = d_streak_q;
    wait_d        = wait_q;
    if (grant_d) begin
      mem_valid_d = 1'b1;
      mem_we_d    = bus.d_we;
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
      mem_mask_d  = bus.d_mask;
      wait_d      = '0;
      // Streak only counts data grants that overtook a waiting fetch.
      if (i_pend)
        d_streak_d = (d_streak_q == STREAK_MAX) ? d_streak_q : d_streak_q + 1'b1;
      else
        d_streak_d = '0;
    end else if (grant_i) begin
      mem_valid_d = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = bus.i_addr;
      mem_wdata_d = '0;
      mem_mask_d  = MASK_WORD;
      wait_d      = '0;
      d_streak_d  = '0;
    end else if (finish) begin
      mem_valid_d = 1'b0;
      wait_d      = '0;
      if (state_q == BUSY_I) begin
        i_ready_d = 1'b1;
        i_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
      end else begin
        d_ready_d = 1'b1;
        d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
      end
    end else if (abort) begin
      mem_valid_d   = 1'b0;
      wait_d        = '0;
      timeout_err_d = 1'b1;
      if (state_q == BUSY_I) i_ready_d = 1'b1;
      else                   d_ready_d = 1'b1;
    end else if (state_q != IDLE) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_mask    = mem_mask_q;
  assign bus.i_ready     = i_ready_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter (MAX_D_STREAK=4, TIMEOUT=8). A vector
// table covers single fetch, simultaneous fetch/store and a byte load; hand
// sequences cover the data-streak cap, wait states, late completion, timeout
// abort and reset during a busy data access.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  memory_arbiter_if bus ();

  memory_arbiter #(
    .MAX_D_STREAK(4),
    .TIMEOUT     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_valid;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic        e_irdy;
    logic [31:0] e_irdata;
    logic        e_drdy;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_mask = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  // Finish anything in flight and return to a quiet IDLE.
  task automatic drain();
    idle_inputs();
    bus.mem_ready = 1'b1;
    repeat (3) step();
    bus.mem_ready = 1'b0;
    step();
  endtask

  task automatic load(input logic [31:0] addr, input logic [3:0] mask);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = addr;
    bus.d_wdata = 32'h0; bus.d_mask = mask;
  endtask

  initial begin
    logic [7:0] grants [8];
    int         ng;
    int         hit;
    logic [7:0] exp_g;
    string      seq_d;

    // vec fields: i_req i_addr d_req d_we d_addr d_wdata d_mask mem_ready mem_rdata |
    //             e_valid e_we e_addr e_wdata e_mask e_irdy e_irdata e_drdy e_drdata
    vecs[0]  = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                 1, 0, 32'h100,  32'h0,        4'hF, 0, 32'h0,  0, 32'h0};
    vecs[1]  = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h13,
                 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h13, 0, 32'h0};
    vecs[2]  = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h55,
                 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,  0, 32'h0};
    vecs[3]  = '{1, 32'h200, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0,  0, 32'h0};
    vecs[4]  = '{1, 32'h200, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h1234,
                 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,  1, 32'h0};
    vecs[5]  = '{1, 32'h200, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0,
                 1, 0, 32'h200,  32'h0,        4'hF, 0, 32'h0,  0, 32'h0};
    vecs[6]  = '{1, 32'h200, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'hAA,
                 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'hAA, 0, 32'h0};
    vecs[7]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,  0, 32'h0};
    vecs[8]  = '{0, 32'h0,   1, 0, 32'h3000, 32'h11111111, 4'h1, 0, 32'h0,
                 1, 0, 32'h3000, 32'h11111111, 4'h1, 0, 32'h0,  0, 32'h0};
    vecs[9]  = '{0, 32'h0,   1, 0, 32'h3000, 32'h11111111, 4'h1, 1, 32'hAB,
                 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,  1, 32'hAB};
    vecs[10] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,  0, 32'h0};

    // ---------------- reset ----------------
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset i_ready", 32'(bus.i_ready), 32'h0);
    chk("reset d_ready", 32'(bus.d_ready), 32'h0);
    chk("reset timeout_err", 32'(bus.timeout_err), 32'h0);
    rst_n = 1'b1;
    step();

    // ---------------- vector table ----------------
    for (int v = 0; v < 11; v++) begin
      bus.i_req = vecs[v].i_req;   bus.i_addr = vecs[v].i_addr;
      bus.d_req = vecs[v].d_req;   bus.d_we = vecs[v].d_we;
      bus.d_addr = vecs[v].d_addr; bus.d_wdata = vecs[v].d_wdata;
      bus.d_mask = vecs[v].d_mask;
      bus.mem_ready = vecs[v].mem_ready; bus.mem_rdata = vecs[v].mem_rdata;
      step();
      chk($sformatf("v%0d mem_valid", v), 32'(bus.mem_valid), 32'(vecs[v].e_valid));
      chk($sformatf("v%0d i_ready", v), 32'(bus.i_ready), 32'(vecs[v].e_irdy));
      chk($sformatf("v%0d d_ready", v), 32'(bus.d_ready), 32'(vecs[v].e_drdy));
      chk($sformatf("v%0d timeout_err", v), 32'(bus.timeout_err), 32'h0);
      if (vecs[v].e_valid) begin
        chk($sformatf("v%0d mem_we", v), 32'(bus.mem_we), 32'(vecs[v].e_we));
        chk($sformatf("v%0d mem_addr", v), bus.mem_addr, vecs[v].e_addr);
        chk($sformatf("v%0d mem_wdata", v), bus.mem_wdata, vecs[v].e_wdata);
        chk($sformatf("v%0d mem_mask", v), 32'(bus.mem_mask), 32'(vecs[v].e_mask));
      end
      if (vecs[v].e_irdy) chk($sformatf("v%0d i_rdata", v), bus.i_rdata, vecs[v].e_irdata);
      if (vecs[v].e_drdy) chk($sformatf("v%0d d_rdata", v), bus.d_rdata, vecs[v].e_drdata);
      $display("[TB] vector %0d: valid=%0b addr=%h i_ready=%0b d_ready=%0b",
               v, bus.mem_valid, bus.mem_addr, bus.i_ready, bus.d_ready);
    end

    // ---------------- data streak cap ----------------
    // Loads held continuously on zero-wait memory. The fetch port presents
    // its request in every cycle except the one carrying d_ready, so each
    // data grant happens with a fetch pending and the streak builds up.
    ng = 0;
    load(32'h4000, MASK_WORD);
    bus.i_addr = 32'h300;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
    for (int t = 0; t < 20; t++) begin
      bus.i_req = ~bus.d_ready;
      step();
      if (bus.mem_valid && ng < 8) begin
        grants[ng] = (bus.mem_addr == 32'h300) ? "I" : "D";
        ng++;
      end
    end
    seq_d = "DDDDID";
    for (int k = 0; k < 6; k++) begin
      exp_g = seq_d[k];
      chk($sformatf("streak grant %0d", k), (k < ng) ? 32'(grants[k]) : 32'h0, 32'(exp_g));
    end
    $display("[TB] streak: %0d grants observed", ng);
    drain();

    // ---------------- wait states on a load ----------------
    load(32'h5000, 4'b0011);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wait cyc%0d mem_valid", k), 32'(bus.mem_valid), 32'h1);
      chk($sformatf("wait cyc%0d mem_addr", k), bus.mem_addr, 32'h5000);
      chk($sformatf("wait cyc%0d mem_mask", k), 32'(bus.mem_mask), 32'h3);
      chk($sformatf("wait cyc%0d d_ready", k), 32'(bus.d_ready), 32'h0);
      if (k < 3) step();
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE0001;
    step();
    chk("wait d_ready", 32'(bus.d_ready), 32'h1);
    chk("wait d_rdata", bus.d_rdata, 32'hCAFE0001);
    chk("wait mem_valid", 32'(bus.mem_valid), 32'h0);
    idle_inputs();
    step();
    chk("wait d_ready pulse", 32'(bus.d_ready), 32'h0);
    $display("[TB] wait-state load done");

    // ---------------- completion in the expiry cycle ----------------
    load(32'h7000, MASK_WORD);
    step();                       // BUSY cycle 1
    repeat (7) step();            // BUSY cycles 2..8
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h600DF00D;
    step();
    chk("late d_ready", 32'(bus.d_ready), 32'h1);
    chk("late d_rdata", bus.d_rdata, 32'h600DF00D);
    chk("late timeout_err", 32'(bus.timeout_err), 32'h0);
    idle_inputs();
    step();
    $display("[TB] late completion done");

    // ---------------- timeout abort ----------------
    load(32'h7100, MASK_WORD);
    bus.mem_rdata = 32'hFFFFFFFF;
    hit = 0;
    for (int k = 1; k <= 20 && hit == 0; k++) begin
      step();
      if (bus.d_ready) hit = k;
    end
    chk("timeout abort step", 32'(hit), 32'd9);
    chk("timeout d_rdata", bus.d_rdata, 32'h0);
    chk("timeout err set", 32'(bus.timeout_err), 32'h1);
    chk("timeout mem_valid", 32'(bus.mem_valid), 32'h0);
    idle_inputs();
    bus.i_req = 1'b1; bus.i_addr = 32'h600;
    step();
    chk("post-timeout grant", bus.mem_addr, 32'h600);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    step();
    chk("post-timeout i_ready", 32'(bus.i_ready), 32'h1);
    chk("post-timeout i_rdata", bus.i_rdata, 32'h12345678);
    chk("timeout err sticky", 32'(bus.timeout_err), 32'h1);
    idle_inputs();
    step();
    $display("[TB] timeout abort done");

    // ---------------- reset during BUSY_D ----------------
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8000;
    bus.d_wdata = 32'h5A5A5A5A; bus.d_mask = MASK_WORD;
    step();
    chk("pre-reset mem_valid", 32'(bus.mem_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset mem_valid", 32'(bus.mem_valid), 32'h0);
    bus.mem_ready = 1'b1;
    step();
    chk("reset no d_ready", 32'(bus.d_ready), 32'h0);
    chk("reset clears timeout_err", 32'(bus.timeout_err), 32'h0);
    idle_inputs();
    rst_n = 1'b1;
    step();
    chk("after reset d_ready", 32'(bus.d_ready), 32'h0);
    chk("after reset mem_valid", 32'(bus.mem_valid), 32'h0);
    bus.i_req = 1'b1; bus.i_addr = 32'h900;
    step();
    chk("after reset grant", bus.mem_addr, 32'h900);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
    step();
    chk("after reset i_rdata", bus.i_ready ? bus.i_rdata : 32'hX, 32'h99);
    idle_inputs();
    step();
    $display("[TB] reset during busy done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-port data/instruction memory between the CPU's instruction-fetch port and its load/store port.
- Sits between the core (PC/fetch logic plus the memory-stage signals derived from control_unit: memory_we, memory_mask) and the unified memory model.
- Grants one requester at a time, holds the memory request stable until the memory completes it, then returns the read data with a one-cycle ready pulse.
- Gives data accesses priority, with a starvation bound for fetch, and aborts transactions the memory never completes.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while a fetch is pending; the next arbitration then goes to fetch.
- TIMEOUT, 64: cycles a granted transaction may wait for mem_ready before it is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request (level).
- i_addr  in  32  fetch address.
- i_ready  out  1  one-cycle pulse: fetch completed.
- i_rdata  out  32  fetched word; valid while i_ready=1.
- d_req  in  1  load/store request (level).
- d_we  in  1  1 = store.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_mask  in  memory_mask_t  byte/half/word mask.
- d_ready  out  1  one-cycle pulse: data access completed.
- d_rdata  out  32  load data; valid while d_ready=1.
- mem_valid  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_mask  out  memory_mask_t  access mask; fetch always uses the word mask.
- mem_ready  in  1  memory completes the current request this cycle; mem_rdata valid.
- mem_rdata  in  32  read data.
- timeout_err  out  1  sticky: some transaction was aborted by timeout.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all outputs 0; d_streak=0; wait counter=0.
  - mem_valid drops immediately, even mid-transaction. No ready pulse is issued for the killed access.
- States: IDLE, BUSY_I, BUSY_D.
- Requester contract:
  - A requester holds req and all its fields stable until its ready pulse.
  - In the cycle its ready=1, that requester's req is ignored by arbitration. In the next cycle it may drop req or present a new request.
- IDLE arbitration, sampled at the clock edge:
  - If d_req and not (i_req and d_streak==MAX_D_STREAK): grant D. Latch d_* into the mem_* registers, mem_valid<=1, go to BUSY_D. d_streak increments (saturating) if i_req=1, else clears.
  - Else if i_req: grant I. mem_addr<=i_addr, mem_we<=0, mem_mask<=word, mem_wdata<=0, mem_valid<=1, go to BUSY_I. d_streak<=0.
  - Else stay in IDLE with mem_valid=0.
- BUSY_x:
  - mem_* outputs are registered and held constant.
  - On mem_ready=1: mem_valid<=0, x_ready<=1, x_rdata<=(mem_we ? 0 : mem_rdata), return to IDLE.
  - i_ready and d_ready are never high in the same cycle; each is high for exactly one cycle per grant.
- Latency:
  - Request first high in cycle N with IDLE: mem_valid is high in N+1.
  - Zero-wait memory (mem_ready in N+1): x_ready in N+2.
  - Back-to-back throughput: one access per 2 cycles. Arbitration occurs in the cycle the ready pulse is output.
- Timeout:
  - The wait counter clears on grant and increments each BUSY cycle with mem_ready=0.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_ready: abort. mem_valid<=0, x_ready<=1, x_rdata<=0, timeout_err<=1 (sticky until reset), go to IDLE.
  - mem_ready arriving in the same cycle as expiry wins: normal completion, no error.
- mem_ready while IDLE is ignored.

Test Plan:
- Fetch only, zero-wait memory, i_addr=0x100, mem_rdata=0x00000013 -> mem_valid cycle N+1 with mem_addr=0x100, mem_we=0; i_ready=1 and i_rdata=0x13 in N+2 only.
- i_req and d_req both rise in the same cycle; d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> data granted first, mem_we=1 with those values; d_ready then d_rdata=0; fetch granted next, i_ready 2 cycles after d_ready.
- d_req held continuously with back-to-back loads while i_req=1, MAX_D_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- Memory inserts 3 wait cycles on a load -> mem_valid/mem_addr/mem_mask stable for 4 cycles; d_ready one cycle after mem_ready, d_rdata equals mem_rdata.
- TIMEOUT=8, mem_ready never asserted -> abort at cycle 8 of BUSY; d_ready=1, d_rdata=0, timeout_err=1 and stays 1; next request is served normally.
- rst_n pulled low during BUSY_D -> mem_valid=0 immediately, no d_ready; after release state is IDLE and timeout_err=0.
